// File: rtl/add_pkg.sv
// Shared types and helpers for the add_acc streaming accumulator.
// Holds the accumulator FSM encoding, default widths and the widening add.
package add_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_e;

  localparam int ADD_DATA_W = 32;
  localparam int ADD_ACC_W  = 40;

  // Adds at 64 bits and reports bit w as the carry out of a w-bit add.
  // Returns {sum, carry}. Both operands must be below 2**w, with w <= 63.
  function automatic logic [64:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] contrib,
                                          input logic [5:0]  w);
    logic [63:0] s;
    s = acc + contrib;
    return {s, s[w]};
  endfunction

endpackage

// File: rtl/add_acc_sat.sv
// Combinational saturating adder of width ACC_W.
// Clamps to all-ones when the add carries out of ACC_W bits.
module add_acc_sat
  import add_pkg::*;
#(
  parameter int DATA_W = ADD_DATA_W,
  parameter int ACC_W  = ADD_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W:0]   contrib,
  output logic [ACC_W-1:0]  acc_next,
  output logic              sat_hit
);

  logic [64:0] res;

  always_comb begin
    res      = sat_add(64'(acc), 64'(contrib), 6'(ACC_W));
    sat_hit  = res[0];
    acc_next = sat_hit ? '1 : ACC_W'(res[64:1]);
  end

endmodule

// File: rtl/add_acc.sv
// Frame accumulator behind the 32-bit add stage: sums {overflow, sum} beats
// per frame and holds one registered result until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a frame
//   ACCUM | frame open, partial sum held between beats
//   HOLD  | frame result presented, input side blocked
module add_acc
  import add_pkg::*;
#(
  parameter int DATA_W  = ADD_DATA_W,
  parameter int ACC_W   = ADD_ACC_W,
  parameter int MAX_LEN = 256,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_overflow,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf_seen,
  output logic              out_sat
);

  acc_state_e state, state_nxt;

  logic [ACC_W-1:0] acc, acc_sum, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, sat, ovf_nxt, sat_nxt;
  logic             sat_hit, accept, first, close;
  logic [DATA_W:0]  contrib;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign first     = (state == IDLE);
  assign contrib   = {in_overflow, in_sum};

  add_acc_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_sat (
    .acc      (acc),
    .contrib  (contrib),
    .acc_next (acc_sum),
    .sat_hit  (sat_hit)
  );

  // The first beat of a frame restarts the sum and clears both sticky flags.
  always_comb begin
    acc_nxt = first ? ACC_W'(contrib) : acc_sum;
    cnt_nxt = first ? CNT_W'(1) : cnt + CNT_W'(1);
    sat_nxt = first ? 1'b0 : (sat | sat_hit);
    ovf_nxt = (first ? 1'b0 : ovf) | in_overflow;
    close   = in_last || (cnt_nxt == CNT_W'(MAX_LEN));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = close ? HOLD : ACCUM;
      HOLD:        if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      sat          <= 1'b0;
      out_acc      <= '0;
      out_count    <= '0;
      out_ovf_seen <= 1'b0;
      out_sat      <= 1'b0;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      sat <= sat_nxt;
      if (close) begin
        out_acc      <= acc_nxt;
        out_count    <= cnt_nxt;
        out_ovf_seen <= ovf_nxt;
        out_sat      <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_add_acc.sv
// Directed bench for add_acc, built with ACC_W=34 and MAX_LEN=4 so that
// saturation and auto-close are reachable with short frames.
module tb_add_acc;
  import add_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ACC_W   = 34;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_overflow, in_last;
  logic              out_valid, out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf_seen, out_sat;

  int n_cmp = 0;
  int n_mis = 0;

  add_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_overflow  (in_overflow),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_acc      (out_acc),
    .out_count    (out_count),
    .out_ovf_seen (out_ovf_seen),
    .out_sat      (out_sat)
  );

  always #5 clk = ~clk;

  // Presents a beat from a falling edge and returns on the falling edge after
  // it has been accepted; the inputs are left driven for the caller.
  task automatic send(input logic [DATA_W-1:0] s, input logic o, input logic l);
    int waited = 0;
    in_valid = 1'b1; in_sum = s; in_overflow = o; in_last = l;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_mis++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_sum = '0; in_overflow = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    idle_in();
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_acc !== '0 || out_count !== '0) begin n_mis++; $display("FAIL reset_out_data: acc=%0h cnt=%0d want 0/0", out_acc, out_count); end
    n_cmp++; if (out_ovf_seen !== 1'b0 || out_sat !== 1'b0) begin n_mis++; $display("FAIL reset_flags: ovf=%0b sat=%0b want 0/0", out_ovf_seen, out_sat); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_simple();
    out_ready = 1'b1;
    send(32'd10, 1'b0, 1'b0);
    send(32'd20, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL simple_early_valid: got %0b want 0", out_valid); end
    send(32'd30, 1'b0, 1'b1);
    idle_in();
    n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL simple_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_acc !== 34'd60) begin n_mis++; $display("FAIL simple_acc: got %0d want 60", out_acc); end
    n_cmp++; if (out_count !== 3'd3) begin n_mis++; $display("FAIL simple_count: got %0d want 3", out_count); end
    n_cmp++; if (out_ovf_seen !== 1'b0 || out_sat !== 1'b0) begin n_mis++; $display("FAIL simple_flags: ovf=%0b sat=%0b want 0/0", out_ovf_seen, out_sat); end
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL simple_hold_ready: got %0b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_mis++; $display("FAIL simple_one_cycle: valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_carry();
    send(32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'h0000_0001, 1'b0, 1'b1);
    idle_in();
    n_cmp++; if (out_acc !== 34'h2_0000_0000) begin n_mis++; $display("FAIL carry_acc: got %0h want 200000000", out_acc); end
    n_cmp++; if (out_ovf_seen !== 1'b1 || out_sat !== 1'b0) begin n_mis++; $display("FAIL carry_flags: ovf=%0b sat=%0b want 1/0", out_ovf_seen, out_sat); end
    n_cmp++; if (out_count !== 3'd2) begin n_mis++; $display("FAIL carry_count: got %0d want 2", out_count); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 1'b1, (i == 3));
    idle_in();
    n_cmp++; if (out_acc !== 34'h3_FFFF_FFFF) begin n_mis++; $display("FAIL sat_acc: got %0h want 3ffffffff", out_acc); end
    n_cmp++; if (out_sat !== 1'b1 || out_ovf_seen !== 1'b1) begin n_mis++; $display("FAIL sat_flags: sat=%0b ovf=%0b want 1/1", out_sat, out_ovf_seen); end
    n_cmp++; if (out_count !== 3'd4) begin n_mis++; $display("FAIL sat_count: got %0d want 4", out_count); end
    @(negedge clk);
    send(32'd5, 1'b0, 1'b1);
    idle_in();
    n_cmp++; if (out_acc !== 34'd5 || out_count !== 3'd1) begin n_mis++; $display("FAIL clear_data: acc=%0h cnt=%0d want 5/1", out_acc, out_count); end
    n_cmp++; if (out_sat !== 1'b0 || out_ovf_seen !== 1'b0) begin n_mis++; $display("FAIL clear_flags: sat=%0b ovf=%0b want 0/0", out_sat, out_ovf_seen); end
    @(negedge clk);
  endtask

  task automatic test_autoclose();
    for (int i = 0; i < 4; i++) send(32'd1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL auto_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_acc !== 34'd4 || out_count !== 3'd4) begin n_mis++; $display("FAIL auto_first: acc=%0d cnt=%0d want 4/4", out_acc, out_count); end
    send(32'd1, 1'b0, 1'b0);
    send(32'd1, 1'b0, 1'b1);
    idle_in();
    n_cmp++; if (out_acc !== 34'd2 || out_count !== 3'd2) begin n_mis++; $display("FAIL auto_second: acc=%0d cnt=%0d want 2/2", out_acc, out_count); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'd3, 1'b0, 1'b0);
    send(32'd4, 1'b0, 1'b1);
    in_sum = 32'd99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== 34'd7 || out_count !== 3'd2) begin
        n_mis++;
        $display("FAIL bp_hold[%0d]: valid=%0b ready=%0b acc=%0d cnt=%0d want 1/0/7/2", i, out_valid, in_ready, out_acc, out_count);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    idle_in();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_release: valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
    n_cmp++; if (out_acc !== 34'd7) begin n_mis++; $display("FAIL bp_ignored_beat: acc=%0d want 7", out_acc); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    send(32'd100, 1'b1, 1'b0);
    send(32'd100, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_mis++; $display("FAIL mid_rst_hs: valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
    n_cmp++; if (out_acc !== '0 || out_count !== '0 || out_ovf_seen !== 1'b0 || out_sat !== 1'b0) begin
      n_mis++; $display("FAIL mid_rst_data: acc=%0h cnt=%0d ovf=%0b sat=%0b want 0", out_acc, out_count, out_ovf_seen, out_sat);
    end
    idle_in();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    send(32'd7, 1'b0, 1'b1);
    idle_in();
    n_cmp++; if (out_acc !== 34'd7 || out_count !== 3'd1 || out_ovf_seen !== 1'b0) begin
      n_mis++; $display("FAIL mid_rst_next: acc=%0d cnt=%0d ovf=%0b want 7/1/0", out_acc, out_count, out_ovf_seen);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_reset();
    out_ready = 1'b0;
    send(32'd9, 1'b0, 1'b1);
    idle_in();
    n_cmp++; if (out_valid !== 1'b1 || out_acc !== 34'd9) begin n_mis++; $display("FAIL hold_rst_pre: valid=%0b acc=%0d want 1/9", out_valid, out_acc); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== '0) begin
      n_mis++; $display("FAIL hold_rst: valid=%0b ready=%0b acc=%0h want 0/1/0", out_valid, in_ready, out_acc);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_simple();
    test_carry();
    test_saturation();
    test_autoclose();
    test_backpressure();
    test_mid_reset();
    test_hold_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/add_acc.md
# add_acc

Streaming accumulator that sits directly downstream of the 32-bit `add` stage. It consumes `{overflow, sum}` results over a valid/ready handshake and sums each frame of results into a wide saturating accumulator. At the end of each frame it presents one registered result (total, beat count, overflow flags) and holds it until the consumer accepts it. It turns per-operation add results into per-frame totals for the downstream reporting logic.

## Interface
Parameters:
- `DATA_W`, 32, width of `in_sum`, matching the adder's `sum`.
- `ACC_W`, 40, accumulator width; must be ≥ `DATA_W`+1.
- `MAX_LEN`, 256, maximum beats per frame; the frame closes automatically at this count.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  an adder result is present.
- `in_ready`  out  1  block can accept a beat.
- `in_sum`  in  `DATA_W`  the adder's `sum`.
- `in_overflow`  in  1  the adder's carry-out (`overflow`).
- `in_last`  in  1  this beat closes the frame.
- `out_valid`  out  1  frame result is held.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  `ACC_W`  frame total, saturated.
- `out_count`  out  `$clog2(MAX_LEN+1)`  beats in the frame (1..`MAX_LEN`).
- `out_ovf_seen`  out  1  at least one beat in the frame had `in_overflow`=1.
- `out_sat`  out  1  the accumulator saturated during the frame.

## Operation
- **Beat contribution.** Each beat contributes `{in_overflow, in_sum}`, a 33-bit unsigned value, zero-extended to `ACC_W`.
- **Accept rule.** A beat is accepted when `in_valid && in_ready`. `in_ready` is 1 in IDLE and ACCUM and 0 in HOLD. It is driven from registered state only, with no combinational path from `out_ready`.
- **State machine.** States are IDLE, ACCUM and HOLD.
  - IDLE: on accept, acc ← contribution and count ← 1. Go to HOLD if the frame closes on that beat, otherwise go to ACCUM.
  - ACCUM: on accept, acc ← sat(acc + contribution) and count ← count+1. Go to HOLD if the frame closes.
  - HOLD: `out_*` are stable while `out_valid`=1. On `out_ready`, go to IDLE.
- **Frame close.** A frame closes on an accepted beat with `in_last`=1, or on the beat that makes count = `MAX_LEN`, whichever comes first.
- **Saturation.** The sum is computed at `ACC_W`+1 bits. If the carry is set, acc ← all-ones and the sticky `sat` flag ← 1. Once saturated, acc stays all-ones for the rest of the frame.
- **Overflow flag.** `ovf_seen` is sticky within a frame (OR of `in_overflow` over accepted beats).
- **Flag reset per frame.** Both flags are cleared when the first beat of a new frame is accepted, then set from that beat.
- **Output register.** On the closing beat, the output register loads the final acc, count and flags.
- **Stalls.** `in_valid` low in ACCUM is a stall: the partial sum is held indefinitely.
- **Reset.** Asserting `rst_n` low at any time, including mid-frame or in HOLD, discards the partial frame and any held result, and returns to IDLE.

## Timing
- **Reset values.**
  - `in_ready`=1.
  - `out_valid`=0.
  - `out_acc`=0, `out_count`=0.
  - `out_ovf_seen`=0, `out_sat`=0.
- **Latency.** `out_valid` rises the cycle after the closing beat is accepted. All outputs come from registers.
- **Throughput.** One beat per cycle inside a frame. Each frame then costs at least one HOLD cycle with `in_ready`=0. If `out_ready` is held at 1, HOLD lasts exactly one cycle and `in_ready` returns to 1 in the following cycle.
- **Output handshake.** `out_valid` stays at 1 until `out_ready` is sampled high. Backpressure on the output holds `in_ready` low for as long as HOLD lasts.
- **In-frame input side.** `in_valid`, `in_sum`, `in_overflow` and `in_last` are sampled only on the accept edge. Values while `in_ready`=0 are ignored.

## Structure
- **Shared package `add_pkg`:**
  - `acc_state_e` enum {IDLE, ACCUM, HOLD}.
  - Default localparams `ADD_DATA_W`=32 and `ADD_ACC_W`=40.
  - Function `sat_add(acc, contrib)`, returning `{sum, carry}`.
- **Sub-module `add_acc_sat`:** a combinational saturating adder of width `ACC_W`, producing `acc_next` and `sat_hit`.
- **Top level:** holds the FSM, the counter, the sticky flags and the output register.

## Test plan
- **Simple frame.** Reset, then 3 beats (sum=10, 20, 30; overflow=0; last on the 3rd) with `out_ready`=1. Expect `out_acc`=60, `out_count`=3, both flags 0, and `out_valid` high for exactly 1 cycle, one cycle after the 3rd beat.
- **Carry handling.** 2 beats: (sum=0xFFFF_FFFF, ovf=1), then (sum=1, ovf=0, last). Expect `out_acc`=0x1_FFFF_FFFF + 1 = 0x2_0000_0000 and `out_ovf_seen`=1.
- **Saturation.** Use `ACC_W`=34 and 4 beats of `{1, 0xFFFF_FFFF}`. Expect `out_acc`=0x3_FFFF_FFFF, `out_sat`=1 and `out_count`=4.
- **Auto-close.** With `MAX_LEN`=4, send 6 beats of sum=1 without `in_last`.
  - First result: acc=4, count=4.
  - Second result (after `in_last` on beat 6): acc=2, count=2.
- **Output backpressure.** Hold `out_ready`=0 for 5 cycles after the frame closes. Expect `out_valid`=1 and `in_ready`=0 throughout, with outputs stable; `in_ready`=1 the cycle after `out_ready` is sampled high.
- **Mid-frame reset.** Pulse `rst_n` low after 2 of 4 beats. Expect all outputs at reset values immediately (asynchronously). The next frame, a single beat of sum=7 with `in_last`, gives acc=7 and count=1.
